// File: rtl/tdes_sequencer.sv
// Control sequencer for a single-core 3DES engine. Walks three DES passes of
// LOAD -> 16 x ROUND -> FINISH, selecting the user key, pass direction and
// subkey index for each pass, then holds the result until the master acks.
module tdes_sequencer (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       start,
  input  logic       enc_dec,
  input  logic       abort,
  input  logic       out_ack,
  output logic       ready,
  output logic       busy,
  output logic [1:0] stage,
  output logic [3:0] round,
  output logic [3:0] subkey_idx,
  output logic [1:0] key_sel,
  output logic       des_mode,
  output logic       load_ip,
  output logic       round_en,
  output logic       pass_end,
  output logic       out_valid,
  output logic       done,
  output logic [7:0] blk_count
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StFinish,
    StHold
  } state_e;

  localparam logic [1:0] LastStage = 2'd2;
  localparam logic [3:0] LastRound = 4'd15;

  state_e     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [3:0] round_q, round_d;
  logic       enc_q, enc_d;
  logic       done_q, done_d;
  logic [7:0] cnt_q, cnt_d;

  logic accept;
  logic in_busy;
  logic mode_enc;

  // A start is taken in IDLE (abort is meaningless there), or in HOLD together
  // with out_ack provided abort does not win.
  assign accept = start & ((state_q == StIdle) |
                           ((state_q == StHold) & out_ack & ~abort));

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats every other request outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        state_d = abort ? StIdle : StRound;
      end
      StRound: begin
        if (abort) begin
          state_d = StIdle;
        end else if (round_q == LastRound) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        if (abort) begin
          state_d = StIdle;
        end else if (stage_q == LastStage) begin
          state_d = StHold;
        end else begin
          state_d = StLoad;
        end
      end
      StHold: begin
        if (abort) begin
          state_d = StIdle;
        end else if (out_ack) begin
          state_d = start ? StLoad : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pass/round counters, latched direction, done flag and block counter.
  always_comb begin
    stage_d = stage_q;
    round_d = round_q;
    enc_d   = enc_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (accept) begin
      stage_d = 2'd0;
      round_d = 4'd0;
      enc_d   = enc_dec;
    end else if (state_d == StIdle) begin
      // Keep IDLE outputs at their reset values whatever path led here.
      stage_d = 2'd0;
      round_d = 4'd0;
    end else begin
      unique case (state_q)
        StRound: begin
          if (round_q != LastRound) round_d = round_q + 4'd1;
        end
        StFinish: begin
          if (stage_q != LastStage) begin
            stage_d = stage_q + 2'd1;
            round_d = 4'd0;
          end else begin
            // Counter moves with the done pulse so both are seen together.
            done_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stage_q <= 2'd0;
      round_q <= 4'd0;
      enc_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      stage_q <= stage_d;
      round_q <= round_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    in_busy    = (state_q == StLoad) | (state_q == StRound) | (state_q == StFinish);
    ready      = (state_q == StIdle);
    busy       = in_busy;
    load_ip    = (state_q == StLoad);
    round_en   = (state_q == StRound);
    pass_end   = (state_q == StFinish);
    out_valid  = (state_q == StHold);
    done       = done_q;
    stage      = stage_q;
    round      = round_q;
    blk_count  = cnt_q;
    // Encrypt is E-D-E with K1/K2/K3; decrypt is D-E-D with K3/K2/K1.
    mode_enc   = enc_q ? (stage_q != 2'd1) : (stage_q == 2'd1);
    des_mode   = 1'b0;
    key_sel    = 2'b00;
    subkey_idx = 4'd0;
    if (in_busy) begin
      des_mode   = mode_enc;
      key_sel    = enc_q ? stage_q : (LastStage - stage_q);
      subkey_idx = mode_enc ? round_q : (LastRound - round_q);
    end
  end

endmodule

// File: tb/tb_tdes_sequencer.sv
// Bench for tdes_sequencer: a cycle-level reference model driven by elapsed
// time since acceptance, a per-cycle trace check and a done/blk_count scoreboard.
module tb_tdes_sequencer;

  logic       HCLK = 1'b0;
  logic       HRESET, start, enc_dec, abort, out_ack;
  logic       ready, busy, des_mode, load_ip, round_en, pass_end, out_valid, done;
  logic [1:0] stage, key_sel;
  logic [3:0] round, subkey_idx;
  logic [7:0] blk_count;

  tdes_sequencer dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .start      (start),
    .enc_dec    (enc_dec),
    .abort      (abort),
    .out_ack    (out_ack),
    .ready      (ready),
    .busy       (busy),
    .stage      (stage),
    .round      (round),
    .subkey_idx (subkey_idx),
    .key_sel    (key_sel),
    .des_mode   (des_mode),
    .load_ip    (load_ip),
    .round_en   (round_en),
    .pass_end   (pass_end),
    .out_valid  (out_valid),
    .done       (done),
    .blk_count  (blk_count)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: ph 0 = idle, 1 = operating (t = cycles since accept, 1..54),
  // 2 = result held.
  int         ph = 0;
  int         t = 0;
  logic       m = 1'b0;
  logic [7:0] cnt = 8'd0;
  logic       done_exp = 1'b0;
  bit         chk_en = 1'b0;

  task automatic model_accept();
    exp_t e;
    ph = 1;
    t  = 1;
    m  = enc_dec;
    e.cyc = cyc + 54;        // three 18-cycle passes, result the cycle after
    e.cnt = cnt + 8'd1;
    sb_q.push_back(e);
  endtask

  always @(posedge HCLK) begin
    cyc++;
    done_exp = 1'b0;
    if (HRESET) begin
      ph = 0;
      t = 0;
      cnt = 8'd0;
      chk_en = 1'b1;
      sb_q.delete();
    end else begin
      case (ph)
        0: if (start) model_accept();
        1: begin
          if (abort) begin
            ph = 0;
            if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
          end else if (t == 54) begin
            ph = 2;
            done_exp = 1'b1;
            cnt = cnt + 8'd1;
          end else begin
            t++;
          end
        end
        default: begin
          if (abort) ph = 0;
          else if (out_ack) begin
            if (start) model_accept();
            else ph = 0;
          end
        end
      endcase
    end
  end

  // Monitor: compare every output against the model, and pop the scoreboard on done.
  always @(negedge HCLK) begin
    logic [27:0] act, exp, msk;
    logic [1:0]  e_stage, e_ks;
    logic [3:0]  e_round, e_sk;
    logic        e_ready, e_busy, e_dm, e_ld, e_ren, e_pe, e_ov;
    int          p, pos;
    exp_t        e;
    if (chk_en) begin
      e_ready = 1'b0; e_busy = 1'b0; e_stage = 2'd0; e_round = 4'd0; e_sk = 4'd0;
      e_ks = 2'd0; e_dm = 1'b0; e_ld = 1'b0; e_ren = 1'b0; e_pe = 1'b0; e_ov = 1'b0;
      msk = '1;
      if (ph == 0) begin
        e_ready = 1'b1;
      end else if (ph == 1) begin
        p   = (t - 1) / 18;
        pos = (t - 1) % 18;
        e_busy  = 1'b1;
        e_ld    = (pos == 0);
        e_ren   = (pos >= 1) && (pos <= 16);
        e_pe    = (pos == 17);
        e_stage = 2'(p);
        e_round = (pos == 0) ? 4'd0 : ((pos <= 16) ? 4'(pos - 1) : 4'd15);
        e_ks    = m ? 2'(p) : 2'(2 - p);
        e_dm    = m ? (p != 1) : (p == 1);
        e_sk    = e_dm ? e_round : 4'd15 - e_round;
      end else begin
        e_ov = 1'b1;
        msk[25:13] = '0;     // pass/key fields are not defined while holding
      end
      act = {ready, busy, stage, round, subkey_idx, key_sel, des_mode,
             load_ip, round_en, pass_end, out_valid, done, blk_count};
      exp = {e_ready, e_busy, e_stage, e_round, e_sk, e_ks, e_dm,
             e_ld, e_ren, e_pe, e_ov, done_exp, cnt};
      checks++;
      if ((act & msk) != (exp & msk)) begin
        errors++;
        $display("FAIL trace cyc=%0d got=%h want=%h mask=%h", cyc, act, exp, msk);
      end
      if (done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d got done=1 want none pending", cyc);
        end else begin
          e = sb_q.pop_front();
          if (cyc != e.cyc || blk_count !== e.cnt) begin
            errors++;
            $display("FAIL done_sb got cyc=%0d cnt=%0d want cyc=%0d cnt=%0d",
                     cyc, blk_count, e.cyc, e.cnt);
          end
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic wait_valid();
    int k = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_valid got out_valid=%b want 1 within 200 cycles", out_valid);
    end
  endtask

  initial begin
    // Reset with start held high: must be ignored.
    HRESET = 1'b1; start = 1'b1; enc_dec = 1'b1; abort = 1'b0; out_ack = 1'b0;
    tick(3);
    HRESET = 1'b0; start = 1'b0; out_ack = 1'b1;   // ack in IDLE is ignored
    tick(2);
    out_ack = 1'b0;

    // Encrypt; start and enc_dec wiggled mid-operation must not disturb it.
    start = 1'b1; enc_dec = 1'b1; tick();
    start = 1'b0; tick(3);
    start = 1'b1; enc_dec = 1'b0; out_ack = 1'b1; tick(4);
    start = 1'b0; out_ack = 1'b0;
    wait_valid();
    tick(10);
    // Ack with a back-to-back decrypt start.
    out_ack = 1'b1; start = 1'b1; enc_dec = 1'b0; tick();
    out_ack = 1'b0; start = 1'b0; enc_dec = 1'b1;
    wait_valid();
    tick(2);
    out_ack = 1'b1; tick();
    out_ack = 1'b0; tick(2);

    // Abort at stage 1, round 7.
    start = 1'b1; enc_dec = 1'b1; tick();
    start = 1'b0; tick(26);
    abort = 1'b1; tick();
    abort = 1'b0; tick(2);

    // Abort with start in IDLE: start still taken. Then abort inside HOLD.
    abort = 1'b1; start = 1'b1; enc_dec = 1'b0; tick();
    abort = 1'b0; start = 1'b0;
    wait_valid();
    tick(3);
    abort = 1'b1; out_ack = 1'b1; start = 1'b1; tick();
    abort = 1'b0; out_ack = 1'b0; start = 1'b0; tick(2);

    // Reset at stage 2, round 3.
    start = 1'b1; enc_dec = 1'b0; tick();
    start = 1'b0; tick(40);
    HRESET = 1'b1; tick();
    HRESET = 1'b0; tick(2);

    // Random traffic.
    repeat (3000) begin
      start   = ($urandom % 8) == 0;
      enc_dec = 1'($urandom);
      abort   = ($urandom % 300) == 0;
      out_ack = ($urandom % 4) == 0;
      tick();
    end
    start = 1'b0; abort = 1'b0; out_ack = 1'b0;

    // 256 back-to-back blocks from a clean counter: blk_count wraps to 0.
    HRESET = 1'b1; tick();
    HRESET = 1'b0; tick();
    start = 1'b1; enc_dec = 1'($urandom); tick();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      wait_valid();
      if (i < 255) begin
        out_ack = 1'b1; start = 1'b1; enc_dec = 1'($urandom); tick();
        out_ack = 1'b0; start = 1'b0;
      end
    end
    tick();
    checks++;
    if (blk_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap got blk_count=%0d want 0", blk_count);
    end
    out_ack = 1'b1; tick();
    out_ack = 1'b0; tick(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got pending=%0d want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
